key_move_ctrl: RTL and testbench

//  Consumes the 8-bit arrow-key scan code produced by the PS/2 keyboard decoder (PS/2-clock domain,
//  0x00 = no key) and turns it into discrete move commands in the system clock domain. Synchronises
//  and debounces the code, and generates a press event plus typematic auto-repeat while held.

---
 rtl/ps2_key_pkg.sv | 48 ++++
 rtl/bus_sync_stable.sv | 58 +++++
 rtl/key_move_ctrl.sv | 139 +++++++++++++
 tb/tb_key_move_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_key_pkg : arrow scan codes, move direction and key FSM types    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package ps2_key_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } move_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOLD_FIRST = 2'd1,
        ST_HOLD_RPT   = 2'd2
    } key_fsm_e;

    typedef struct packed {
        logic      vld;
        move_dir_e dir;
    } key_dec_t;

    // Anything that is not one of the four arrows decodes as "no direction".
    function automatic key_dec_t decode_key(input logic [7:0] code);
        key_dec_t r;
        r.vld = 1'b1;
        r.dir = DIR_UP;
        case (code)
            KEY_UP:    r.dir = DIR_UP;
            KEY_DOWN:  r.dir = DIR_DOWN;
            KEY_LEFT:  r.dir = DIR_LEFT;
            KEY_RIGHT: r.dir = DIR_RIGHT;
            default:   r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sync_stable.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_sync_stable : per-bit 2-flop synchroniser + word stability filter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bus_sync_stable #(
    parameter int W          = 8,
    parameter int STABLE_CYC = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    localparam int              c_cnt_w  = $clog2(STABLE_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYC);

    logic [W-1:0]       r_meta;
    logic [W-1:0]       r_sync;
    logic [W-1:0]       r_prev;
    logic [W-1:0]       r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    // Run length of identical synced samples, saturating at STABLE_CYC.
    always_comb begin
        if (r_sync != r_prev) begin
            w_cnt_nxt = c_cnt_w'(1);
        end else if (r_cnt == c_stable) begin
            w_cnt_nxt = c_stable;
        end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_acc  <= '0;
            r_cnt  <= c_stable;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == c_stable) begin
                r_acc <= r_sync;
            end
        end
    end

    assign o_data = r_acc;

endmodule
`default_nettype wire

// File: rtl/key_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_move_ctrl : debounced arrow keys -> press/typematic move cmds   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module key_move_ctrl
    import ps2_key_pkg::*;
#(
    parameter int STABLE_CYC = 16,
    parameter int DELAY_CYC  = 25_000_000,
    parameter int RATE_CYC   = 5_000_000,
    parameter int CNT_W      = 25
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_key_code,
    input  logic       i_move_ready,
    output logic       o_move_valid,
    output logic [1:0] o_move_dir,
    output logic       o_move_rpt,
    output logic       o_drop
);

    localparam logic [CNT_W-1:0] c_delay_ld = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] c_rate_ld  = CNT_W'(RATE_CYC - 1);

    logic [7:0]       w_code;
    key_dec_t         w_dec;
    key_fsm_e         r_state;
    key_fsm_e         w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    move_dir_e        r_hold_dir;
    move_dir_e        w_hold_dir_nxt;
    logic             w_evt;
    logic             w_evt_rpt;
    logic             w_xfer;
    logic             r_valid;
    move_dir_e        r_dir;
    logic             r_rpt;
    logic             r_drop;

    bus_sync_stable #(
        .W          (8),
        .STABLE_CYC (STABLE_CYC)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_key_code),
        .o_data  (w_code)
    );

    assign w_dec = decode_key(w_code);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_hold_dir <= DIR_UP;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_hold_dir <= w_hold_dir_nxt;
        end
    end

    // Release and direction change are tested before expiry so they win.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = (r_timer != '0) ? (r_timer - CNT_W'(1)) : '0;
        w_hold_dir_nxt = r_hold_dir;
        w_evt          = 1'b0;
        w_evt_rpt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (w_dec.vld) begin
                    w_evt          = 1'b1;
                    w_timer_nxt    = c_delay_ld;
                    w_hold_dir_nxt = w_dec.dir;
                    w_state_nxt    = ST_HOLD_FIRST;
                end
            end
            ST_HOLD_FIRST, ST_HOLD_RPT: begin
                if (!w_dec.vld) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if (w_dec.dir != r_hold_dir) begin
                    w_evt          = 1'b1;
                    w_timer_nxt    = c_delay_ld;
                    w_hold_dir_nxt = w_dec.dir;
                    w_state_nxt    = ST_HOLD_FIRST;
                end else if (r_timer == '0) begin
                    w_evt       = 1'b1;
                    w_evt_rpt   = 1'b1;
                    w_timer_nxt = c_rate_ld;
                    w_state_nxt = ST_HOLD_RPT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign w_xfer = r_valid & i_move_ready;

    // Single-entry command register: presses replace a stalled entry, repeats never do.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_dir   <= DIR_UP;
            r_rpt   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_evt) begin
                if (!r_valid || w_xfer || !w_evt_rpt) begin
                    r_valid <= 1'b1;
                    r_dir   <= w_dec.dir;
                    r_rpt   <= w_evt_rpt;
                    r_drop  <= r_valid & ~w_xfer;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_move_valid = r_valid;
    assign o_move_dir   = r_dir;
    assign o_move_rpt   = r_rpt;
    assign o_drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_move_ctrl : randomised + directed bench with reference model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_key_move_ctrl;

    localparam int S   = 4;
    localparam int DLY = 20;
    localparam int RT  = 8;
    localparam int HN  = S + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key   = 8'h00;
    logic       ready = 1'b1;
    logic       valid;
    logic [1:0] dir;
    logic       rpt;
    logic       drop;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    key_move_ctrl #(
        .STABLE_CYC (S),
        .DELAY_CYC  (DLY),
        .RATE_CYC   (RT),
        .CNT_W      (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_code   (key),
        .i_move_ready (ready),
        .o_move_valid (valid),
        .o_move_dir   (dir),
        .o_move_rpt   (rpt),
        .o_drop       (drop)
    );

    // Reference model: code history, accepted code, hold tracking by absolute due time, one-slot output.
    logic [7:0] hist [HN];
    logic [7:0] acc;
    bit         holding;
    logic [1:0] hold_dir;
    int         cyc;
    int         due;
    bit         m_valid;
    logic [1:0] m_dir;
    bit         m_rpt;
    bit         m_drop;

    function automatic logic [2:0] arrow(input logic [7:0] c);
        case (c)
            8'h75:   return 3'b100;
            8'h72:   return 3'b101;
            8'h6B:   return 3'b110;
            8'h74:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [4:0] got_v();
        return {valid, valid ? dir : 2'b00, valid ? rpt : 1'b0, drop};
    endfunction

    function automatic logic [4:0] exp_v();
        return {m_valid, m_valid ? m_dir : 2'b00, m_valid ? m_rpt : 1'b0, m_drop};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = 8'h00;
        acc = 8'h00; holding = 0; hold_dir = 2'b00; cyc = 0; due = 0;
        m_valid = 0; m_dir = 2'b00; m_rpt = 0; m_drop = 0;
    endtask

    task automatic model_clock(input logic [7:0] code, input bit rdy);
        logic [2:0] a;
        bit ev, ev_rpt, xfer, same;
        a = arrow(acc);
        ev = 0; ev_rpt = 0;
        if (!a[2]) begin
            holding = 0;
        end else if (!holding || a[1:0] != hold_dir) begin
            ev = 1; holding = 1; hold_dir = a[1:0]; due = cyc + DLY;
        end else if (cyc == due) begin
            ev = 1; ev_rpt = 1; due = cyc + RT;
        end
        xfer = m_valid && rdy;
        m_drop = 0;
        if (ev) begin
            if (m_valid && !xfer && ev_rpt) begin
                m_drop = 1;
            end else begin
                m_drop = m_valid && !xfer;
                m_valid = 1; m_dir = a[1:0]; m_rpt = ev_rpt;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
        for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = code;
        same = 1;
        for (int i = 3; i < HN; i++) if (hist[i] != hist[2]) same = 0;
        if (same) acc = hist[2];
        cyc++;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input logic [7:0] code, input bit rdy);
        key = code; ready = rdy;
        model_clock(code, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first, nv;
        logic [7:0] sc [2] = '{8'h75, 8'h00};
        int         sl [2] = '{20, 15};
        int step;
        rst_n = 0; key = 8'h75; ready = 1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({valid, dir, rpt, drop} !== 5'b0) $display("FAIL reset_outputs: dut=%b want 00000", {valid, dir, rpt, drop});
        else n_pass++;
        rst_n = 1; model_reset();
        first = -1; nv = 0; step = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], 1);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL reset_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            if (valid) begin nv++; if (first < 0) first = step; end
        end
        n_chk++;
        if (first !== 7 || nv !== 1) $display("FAIL reset_first_press: first=%0d count=%0d want 7/1", first, nv);
        else n_pass++;
    endtask

    task automatic test_hold_repeat();
        logic [7:0] sc [2] = '{8'h74, 8'h00};
        int         sl [2] = '{60, 40};
        int off [6] = '{0, 20, 28, 36, 44, 52};
        int vt[$];
        bit vr[$];
        int step = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], 1);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL hold_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            if (valid) begin vt.push_back(step); vr.push_back(rpt); end
        end
        n_chk++;
        if (vt.size() != 6) $display("FAIL hold_count: events=%0d want 6", vt.size());
        else begin
            n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (vt[i] - vt[0] != off[i] || vr[i] != (i != 0))
                    $display("FAIL hold_event%0d: offset=%0d rpt=%0d want %0d/%0d", i, vt[i] - vt[0], vr[i], off[i], i != 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] sc [4] = '{8'h6B, 8'h00, 8'h6B, 8'h00};
        int         sl [4] = '{3, 20, 5, 30};
        int nv = 0, ldir = -1, step = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], 1);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL glitch_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            if (valid) begin nv++; ldir = dir; end
        end
        n_chk++;
        if (nv !== 1 || ldir !== 2) $display("FAIL glitch_events: count=%0d dir=%0d want 1/2", nv, ldir);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] sc [3] = '{8'h72, 8'h72, 8'h00};
        int         sl [3] = '{40, 4, 30};
        bit         sr [3] = '{0, 1, 1};
        logic [4:0] lg [80];
        int nd = 0, step = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], sr[s]);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL bp_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            lg[step] = got_v();
            if (step <= 40 && drop) nd++;
        end
        n_chk++;
        if (nd !== 2 || lg[40] !== 5'b10100) $display("FAIL bp_stall: drops=%0d last=%b want 2/10100", nd, lg[40]);
        else n_pass++;
        n_chk++;
        if (lg[41][4] !== 1'b0 || lg[42][4] !== 1'b0 || lg[43] !== 5'b10110)
            $display("FAIL bp_resume: s41=%b s42=%b s43=%b want 0xxxx/0xxxx/10110", lg[41], lg[42], lg[43]);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        logic [7:0] sc [3] = '{8'h75, 8'h72, 8'h00};
        int         sl [3] = '{10, 12, 25};
        bit         sr [3] = '{0, 0, 1};
        logic [4:0] last = '0;
        int nd = 0, step = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], sr[s]);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL ovw_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            if (drop) nd++;
            if (step == 22) last = got_v();
        end
        n_chk++;
        if (nd !== 1 || last !== 5'b10100) $display("FAIL ovw_result: drops=%0d pending=%b want 1/10100", nd, last);
        else n_pass++;
    endtask

    task automatic test_nonarrow_async_reset();
        logic [7:0] sc [4] = '{8'h1C, 8'hF0, 8'h74, 8'h74};
        int         sl [4] = '{20, 20, 26, 4};
        bit         sr [4] = '{1, 1, 1, 0};
        int nv = 0, step = 0, first = -1;
        bit sawdrop = 0;
        foreach (sc[s]) for (int k = 0; k < sl[s]; k++) begin
            step++; tick(sc[s], sr[s]);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL nonarrow_model step %0d: dut=%b model=%b", step, got_v(), exp_v());
            else n_pass++;
            if (step <= 40 && valid) nv++;
        end
        n_chk++;
        if (nv !== 0 || {valid, rpt} !== 2'b11) $display("FAIL nonarrow_hold: events=%0d valid/rpt=%b want 0/11", nv, {valid, rpt});
        else n_pass++;
        #2 rst_n = 0;
        #1;
        n_chk++;
        if ({valid, dir, rpt, drop} !== 5'b0) $display("FAIL async_reset_now: dut=%b want 00000", {valid, dir, rpt, drop});
        else n_pass++;
        repeat (3) begin @(negedge clk); if (drop) sawdrop = 1; end
        n_chk++;
        if (sawdrop || valid) $display("FAIL async_reset_hold: drop=%0d valid=%0d want 0/0", sawdrop, valid);
        else n_pass++;
        rst_n = 1; model_reset();
        for (int k = 1; k <= 30; k++) begin
            tick(k <= 15 ? 8'h74 : 8'h00, 1);
            n_chk++;
            if (got_v() !== exp_v()) $display("FAIL redetect_model step %0d: dut=%b model=%b", k, got_v(), exp_v());
            else n_pass++;
            if (valid && first < 0) first = k;
        end
        n_chk++;
        if (first !== 7) $display("FAIL redetect_press: first=%0d want 7", first);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] codes [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h00, 8'h1C};
        logic [7:0] c;
        int len;
        for (int s = 0; s < 40; s++) begin
            c = codes[$urandom_range(0, 5)];
            len = $urandom_range(1, 25);
            for (int k = 0; k < len; k++) begin
                tick(c, $urandom_range(0, 3) != 0);
                n_chk++;
                if (got_v() !== exp_v()) $display("FAIL random_model seg %0d: dut=%b model=%b", s, got_v(), exp_v());
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_hold_repeat();
        test_glitch();
        test_backpressure();
        test_overwrite();
        test_nonarrow_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
